// File: rtl/external_interrupt_sender_pkg.sv
// rtl/external_interrupt_sender_pkg.sv - shared types for the external-interrupt sender
package external_interrupt_sender_pkg;

    localparam int RSD_EXTERNAL_INTERRUPT_CODE_WIDTH = 5;

    typedef logic [RSD_EXTERNAL_INTERRUPT_CODE_WIDTH-1:0] ExternalInterruptCodePath;

    typedef enum logic {
        EIS_IDLE = 1'b0,
        EIS_REQ  = 1'b1
    } ExtIntSenderState;

    function automatic ExternalInterruptCodePath toInterruptCode(input int idx);
        return ExternalInterruptCodePath'(idx);
    endfunction

endpackage

// File: rtl/interrupt_priority_encoder.sv
// rtl/interrupt_priority_encoder.sv - lowest-index-first priority encoder over request lines
module interrupt_priority_encoder
    import external_interrupt_sender_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic [NUM_SOURCES-1:0]  requests,
    output logic                    valid,
    output ExternalInterruptCodePath code
);

    // Scan downwards so the last hit, i.e. the lowest index, wins.
    always_comb begin
        valid = 1'b0;
        code  = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (requests[i]) begin
                valid = 1'b1;
                code  = toInterruptCode(i);
            end
        end
    end

endmodule

// File: rtl/external_interrupt_sender.sv
// rtl/external_interrupt_sender.sv - latches peripheral interrupt edges and requests them one at a time
module external_interrupt_sender
    import external_interrupt_sender_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int LOST_CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SOURCES-1:0]   irqIn,
    input  logic [NUM_SOURCES-1:0]   irqEnable,
    output logic                     reqExternalInterrupt,
    output ExternalInterruptCodePath externalInterruptCode,
    input  logic                     ackExternalInterrupt,
    output logic [NUM_SOURCES-1:0]   pending,
    output logic [LOST_CNT_W-1:0]    lostCount
);

    localparam int SUM_W = LOST_CNT_W + 6;

    generate
        if (NUM_SOURCES < 1 || NUM_SOURCES > (1 << RSD_EXTERNAL_INTERRUPT_CODE_WIDTH)) begin : gBadNumSources
            $error("external_interrupt_sender: NUM_SOURCES out of range for code width");
        end
    endgenerate

    ExtIntSenderState         state;
    logic [NUM_SOURCES-1:0]   irqPrev;
    logic [NUM_SOURCES-1:0]   rise;
    logic [NUM_SOURCES-1:0]   retire;
    logic [NUM_SOURCES-1:0]   lostEdges;
    logic [NUM_SOURCES-1:0]   pendingNext;
    logic [SUM_W-1:0]         lostIncrement;
    logic [SUM_W-1:0]         lostSum;
    logic [LOST_CNT_W-1:0]    lostNext;
    logic                     ackTaken;
    logic                     selValid;
    ExternalInterruptCodePath selCode;

    assign rise     = irqIn & ~irqPrev & irqEnable;
    assign ackTaken = (state == EIS_REQ) && ackExternalInterrupt;

    interrupt_priority_encoder #(
        .NUM_SOURCES(NUM_SOURCES)
    ) uEncoder (
        .requests(pending & irqEnable),
        .valid   (selValid),
        .code    (selCode)
    );

    // A rise on the source being retired re-arms it instead of counting as lost.
    always_comb begin
        retire = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            retire[i] = ackTaken && (externalInterruptCode == toInterruptCode(i));
        end
        lostEdges   = rise & pending & ~retire;
        pendingNext = (pending & ~retire) | rise;
    end

    always_comb begin
        lostIncrement = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            lostIncrement = lostIncrement + SUM_W'(lostEdges[i]);
        end
        lostSum = SUM_W'(lostCount) + lostIncrement;
        if (lostSum > SUM_W'({LOST_CNT_W{1'b1}})) begin
            lostNext = '1;
        end else begin
            lostNext = lostSum[LOST_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irqPrev   <= '1;
            pending   <= '0;
            lostCount <= '0;
        end else begin
            irqPrev   <= irqIn;
            pending   <= pendingNext;
            lostCount <= lostNext;
        end
    end

    // Selection reads the registered pending vector, so a fresh edge reaches req one cycle later
    // and a retired request always leaves at least one idle cycle before the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= EIS_IDLE;
            reqExternalInterrupt  <= 1'b0;
            externalInterruptCode <= '0;
        end else begin
            case (state)
                EIS_IDLE: begin
                    if (selValid) begin
                        state                 <= EIS_REQ;
                        reqExternalInterrupt  <= 1'b1;
                        externalInterruptCode <= selCode;
                    end
                end
                EIS_REQ: begin
                    if (ackExternalInterrupt) begin
                        state                <= EIS_IDLE;
                        reqExternalInterrupt <= 1'b0;
                    end
                end
                default: begin
                    state                <= EIS_IDLE;
                    reqExternalInterrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_external_interrupt_sender.sv
// tb/tb_external_interrupt_sender.sv - scoreboard bench for external_interrupt_sender
module tb_external_interrupt_sender;
    import external_interrupt_sender_pkg::*;

    localparam int N = 8;
    localparam int LOST_MAX = 255;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             irqIn;
    logic [N-1:0]             irqEnable;
    logic                     reqExternalInterrupt;
    ExternalInterruptCodePath externalInterruptCode;
    logic                     ackExternalInterrupt;
    logic [N-1:0]             pending;
    logic [7:0]               lostCount;

    int errors = 0;
    int checks = 0;

    bit mPend[N];
    bit mPrev[N];
    int mLost;
    int mServing;
    int expQ[$];

    external_interrupt_sender #(.NUM_SOURCES(N), .LOST_CNT_W(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .irqIn                (irqIn),
        .irqEnable            (irqEnable),
        .reqExternalInterrupt (reqExternalInterrupt),
        .externalInterruptCode(externalInterruptCode),
        .ackExternalInterrupt (ackExternalInterrupt),
        .pending              (pending),
        .lostCount            (lostCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: pending set of sources, a lost-event tally and the source currently being served.
    task automatic modelStep();
        bit rise[N];
        bit newPend[N];
        bit done;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mPend[i] = 0;
                mPrev[i] = 1;
            end
            mLost = 0;
            mServing = -1;
            expQ.delete();
            return;
        end
        done = (mServing >= 0) && ackExternalInterrupt;
        for (int i = 0; i < N; i++) begin
            rise[i] = irqIn[i] && !mPrev[i] && irqEnable[i];
            newPend[i] = mPend[i];
        end
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                if (mPend[i] && !(done && i == mServing) && mLost < LOST_MAX) mLost++;
                newPend[i] = 1;
            end
        end
        if (done) begin
            if (!rise[mServing]) newPend[mServing] = 0;
            mServing = -1;
        end else if (mServing < 0) begin
            for (int i = 0; i < N; i++) begin
                if (mPend[i] && irqEnable[i]) begin
                    mServing = i;
                    expQ.push_back(i);
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            mPend[i] = newPend[i];
            mPrev[i] = irqIn[i];
        end
    endtask

    function automatic int modelPendingBits();
        int v = 0;
        for (int i = 0; i < N; i++) if (mPend[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        chk("req", reqExternalInterrupt, (mServing >= 0) ? 1 : 0);
        chk("pending", pending, modelPendingBits());
        chk("lostCount", lostCount, mLost);
        if (mServing >= 0) chk("code", externalInterruptCode, mServing);
    endtask

    // Monitor: every accepted handshake must carry the next code the model issued.
    always @(negedge clk) begin
        if (!rst && reqExternalInterrupt && ackExternalInterrupt) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL handshake: got code %0d expected none", externalInterruptCode);
            end else begin
                int e;
                e = expQ.pop_front();
                if (externalInterruptCode != ExternalInterruptCodePath'(e)) begin
                    errors++;
                    $display("FAIL handshake: got code %0d expected %0d", externalInterruptCode, e);
                end
            end
        end
    end

    task automatic ackOnce();
        ackExternalInterrupt = 1'b1;
        tick();
        ackExternalInterrupt = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        irqIn = 8'h01;
        irqEnable = 8'hFF;
        ackExternalInterrupt = 1'b0;

        // 1: line already high through reset must not fire
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("t1_req_idle", reqExternalInterrupt, 0);
        chk("t1_pending_idle", pending, 0);
        irqIn = 8'h09;
        tick();
        irqIn = 8'h01;
        tick();
        chk("t1_req", reqExternalInterrupt, 1);
        chk("t1_code", externalInterruptCode, 3);
        ackOnce();
        tick();

        // 2: simultaneous rises served lowest first with a one-cycle gap
        irqIn = 8'h25;
        tick();
        irqIn = 8'h01;
        tick();
        chk("t2_code_first", externalInterruptCode, 2);
        repeat (4) tick();
        ackOnce();
        chk("t2_gap", reqExternalInterrupt, 0);
        tick();
        chk("t2_req_second", reqExternalInterrupt, 1);
        chk("t2_code_second", externalInterruptCode, 5);
        repeat (4) tick();
        ackOnce();
        tick();

        // 3: repeated edges on a pending source are counted as lost
        for (int k = 0; k < 3; k++) begin
            irqIn = 8'h03;
            tick();
            irqIn = 8'h01;
            tick();
        end
        chk("t3_lost", lostCount, 2);
        chk("t3_code", externalInterruptCode, 1);
        ackOnce();
        chk("t3_pending_cleared", pending[1], 0);
        repeat (2) tick();
        chk("t3_single_req", reqExternalInterrupt, 0);

        // 4: disabling the served source does not withdraw it; disabled edges are dropped
        irqIn = 8'h11;
        tick();
        irqIn = 8'h01;
        tick();
        irqEnable = 8'hEF;
        repeat (2) tick();
        chk("t4_req_held", reqExternalInterrupt, 1);
        chk("t4_code_held", externalInterruptCode, 4);
        irqEnable = 8'hAF;
        irqIn = 8'h41;
        tick();
        irqIn = 8'h01;
        tick();
        chk("t4_disabled_edge", pending[6], 0);
        ackOnce();
        chk("t4_req_done", reqExternalInterrupt, 0);
        irqEnable = 8'hFF;
        tick();

        // 5: ack coincident with a fresh rise of the same source re-arms it
        irqIn = 8'h00;
        tick();
        irqIn = 8'h01;
        tick();
        irqIn = 8'h00;
        tick();
        chk("t5_code", externalInterruptCode, 0);
        irqIn = 8'h01;
        ackOnce();
        chk("t5_req_gap", reqExternalInterrupt, 0);
        chk("t5_repend", pending[0], 1);
        chk("t5_lost_same", lostCount, 2);
        tick();
        chk("t5_req_again", reqExternalInterrupt, 1);
        chk("t5_code_again", externalInterruptCode, 0);
        ackOnce();
        tick();

        // 6: reset during a request, late ack ignored
        irqIn = 8'h81;
        tick();
        irqIn = 8'h01;
        tick();
        chk("t6_req", reqExternalInterrupt, 1);
        rst = 1'b1;
        ackExternalInterrupt = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req_reset", reqExternalInterrupt, 0);
        chk("t6_pending_reset", pending, 0);
        chk("t6_state", dut.state, EIS_IDLE);
        repeat (2) tick();
        chk("t6_state_after_ack", dut.state, EIS_IDLE);
        ackExternalInterrupt = 1'b0;
        tick();

        // Random phase
        for (int c = 0; c < 800; c++) begin
            irqIn = 8'($urandom);
            irqEnable = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ackExternalInterrupt = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        irqEnable = 8'hFF;
        ackExternalInterrupt = 1'b1;
        for (int c = 0; c < 100 && (mServing >= 0 || modelPendingBits() != 0); c++) tick();
        ackExternalInterrupt = 1'b0;
        tick();
        chk("drain_pending", pending, 0);
        chk("drain_queue", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
